// File: rtl/aes_pkg.sv
`default_nettype none
// =====================================================================
// aes_pkg: shared FSM states, error codes and Nk helpers. Rev 1.0
// =====================================================================
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_CRYPT  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_NK  = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

  localparam logic [7:0] NK_128 = 8'd4;
  localparam logic [7:0] NK_192 = 8'd6;
  localparam logic [7:0] NK_256 = 8'd8;

  localparam int KEY_MAX_W = 256;

  function automatic logic nk_legal(input logic [7:0] nk);
    return (nk == NK_128) || (nk == NK_192) || (nk == NK_256);
  endfunction

  // Keys are MSB-aligned, so only the top 32*Nk bits are significant.
  function automatic logic [KEY_MAX_W-1:0] key_mask(input logic [7:0] nk);
    logic [KEY_MAX_W-1:0] m;
    m = '0;
    case (nk)
      NK_128:  m[KEY_MAX_W-1 -: 128] = '1;
      NK_192:  m[KEY_MAX_W-1 -: 192] = '1;
      NK_256:  m = '1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_watchdog.sv
`default_nettype none
// =====================================================================
// aes_watchdog: clearable cycle counter with expiry flag. Rev 1.0
// =====================================================================
module aes_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMO_W          = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TMO_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == TMO_W'(TIMEOUT_CYCLES));

endmodule
`default_nettype wire

// File: rtl/aes_request_sequencer.sv
`default_nettype none
// =====================================================================
// aes_request_sequencer: valid/ready front end sequencing AES cores. Rev 1.0
// =====================================================================
module aes_request_sequencer
  import aes_pkg::*;
#(
  parameter int DATA_W         = 128,
  parameter int KEY_W          = 256,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMO_W          = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_decrypt,
  input  logic [7:0]        in_nk,
  input  logic [KEY_W-1:0]  in_key,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_err,
  output logic              ke_reset,
  output logic [KEY_W-1:0]  ke_key,
  output logic [7:0]        ke_nk,
  input  logic              ke_done,
  output logic              cip_reset,
  input  logic              cip_done,
  input  logic [DATA_W-1:0] cip_result,
  output logic              dec_reset,
  input  logic              dec_done,
  input  logic [DATA_W-1:0] dec_result,
  output logic [DATA_W-1:0] core_data
);

  state_t r_state, w_next;

  logic                 r_decrypt;
  logic                 r_cache_valid;
  logic [KEY_W-1:0]     r_cache_key;
  logic [7:0]           r_cache_nk;
  logic                 r_ke_hold;
  logic                 r_flush_seen;

  logic                 w_accept;
  logic                 w_nk_ok;
  logic                 w_hit;
  logic                 w_tmo;
  logic                 w_wd_clear;
  logic                 w_wd_enable;
  logic                 w_core_done;
  logic [DATA_W-1:0]    w_core_result;
  logic [KEY_MAX_W-1:0] w_in_mask_full;
  logic [KEY_MAX_W-1:0] w_ke_mask_full;
  logic [KEY_W-1:0]     w_in_mask;
  logic [KEY_W-1:0]     w_ke_mask;

  assign w_in_mask_full = key_mask(in_nk);
  assign w_ke_mask_full = key_mask(ke_nk);
  assign w_in_mask      = w_in_mask_full[KEY_MAX_W-1 -: KEY_W];
  assign w_ke_mask      = w_ke_mask_full[KEY_MAX_W-1 -: KEY_W];

  assign w_accept      = in_valid && (r_state == ST_IDLE);
  assign w_nk_ok       = nk_legal(in_nk);
  // A flush in the accept cycle must force a miss.
  assign w_hit         = r_cache_valid && !flush && (r_cache_nk == in_nk) &&
                         ((in_key & w_in_mask) == r_cache_key);
  assign w_core_done   = r_decrypt ? dec_done : cip_done;
  assign w_core_result = r_decrypt ? dec_result : cip_result;

  aes_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMO_W          (TMO_W)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (w_wd_clear),
    .enable  (w_wd_enable),
    .expired (w_tmo)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (!w_nk_ok)   w_next = ST_RESP;
          else if (w_hit) w_next = ST_CRYPT;
          else            w_next = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        if (ke_done)    w_next = ST_CRYPT;
        else if (w_tmo) w_next = ST_RESP;
      end
      ST_CRYPT: begin
        if (w_core_done || w_tmo) w_next = ST_RESP;
      end
      ST_RESP: begin
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // The watchdog restarts on every state change so each wait gets its own budget.
  assign w_wd_enable = (r_state == ST_EXPAND) || (r_state == ST_CRYPT);
  assign w_wd_clear  = !w_wd_enable || (w_next != r_state);

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_RESP);
  assign ke_reset  = r_ke_hold || (w_accept && w_nk_ok && !w_hit);
  assign cip_reset = !((r_state == ST_CRYPT) && !r_decrypt);
  assign dec_reset = !((r_state == ST_CRYPT) &&  r_decrypt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_decrypt     <= 1'b0;
      ke_key        <= '0;
      ke_nk         <= '0;
      core_data     <= '0;
      out_data      <= '0;
      out_err       <= ERR_OK;
      r_cache_valid <= 1'b0;
      r_cache_key   <= '0;
      r_cache_nk    <= '0;
      r_ke_hold     <= 1'b1;
      r_flush_seen  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_decrypt <= in_decrypt;
            if (!w_nk_ok) begin
              out_data <= '0;
              out_err  <= ERR_NK;
            end else begin
              ke_key    <= in_key;
              ke_nk     <= in_nk;
              core_data <= in_data;
              if (!w_hit) begin
                r_cache_valid <= 1'b0;
                r_ke_hold     <= 1'b0;
                r_flush_seen  <= 1'b0;
              end
            end
          end
        end
        ST_EXPAND: begin
          if (flush) r_flush_seen <= 1'b1;
          if (ke_done) begin
            r_cache_key   <= ke_key & w_ke_mask;
            r_cache_nk    <= ke_nk;
            r_cache_valid <= !r_flush_seen;
          end else if (w_tmo) begin
            r_ke_hold     <= 1'b1;
            r_cache_valid <= 1'b0;
            out_data      <= '0;
            out_err       <= ERR_TMO;
          end
        end
        ST_CRYPT: begin
          if (w_core_done) begin
            out_data <= w_core_result;
            out_err  <= ERR_OK;
          end else if (w_tmo) begin
            out_data <= '0;
            out_err  <= ERR_TMO;
          end
        end
        default: ;
      endcase
      if (flush) r_cache_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/aes_request_sequencer.md
Name: aes_request_sequencer

Overview:
Request-driven controller wrapping the KeyExpansion, Cipher and Decipher cores; replaces hand-sequenced core resets with a valid/ready front end. Supports AES-128/192/256 (Nk 4/6/8) and encrypt/decrypt per request. Caches the expanded key so back-to-back requests with the same key skip expansion. Adds a watchdog timeout and error reporting. Sits between the system bus adapter and the three AES cores.

Parameters:
DATA_W, 128, block width in bits
KEY_W, 256, key port width; shorter keys are MSB-aligned, unused LSBs ignored
TIMEOUT_CYCLES, 255, max cycles spent waiting on any core done before abort
TMO_W, 8, watchdog counter width; must satisfy 2^TMO_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  single-cycle pulse; invalidates the key cache
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid&in_ready
in_decrypt  in  1  0 = encrypt, 1 = decrypt
in_nk  in  8  key length in words: 4, 6 or 8
in_key  in  KEY_W  cipher key
in_data  in  DATA_W  plaintext or ciphertext
out_valid  out  1  response valid
out_ready  in  1  response consumed when out_valid&out_ready
out_data  out  DATA_W  result block
out_err  out  2  00 ok, 01 illegal Nk, 10 timeout
ke_reset  out  1  active-high reset to KeyExpansion
ke_key  out  KEY_W  registered key to KeyExpansion
ke_nk  out  8  registered Nk to all cores
ke_done  in  1  KeyExpansion done, level, held until ke_reset
cip_reset  out  1  active-high reset to Cipher
cip_done  in  1  Cipher done, level
cip_result  in  DATA_W  Cipher output
dec_reset  out  1  active-high reset to Decipher
dec_done  in  1  Decipher done, level
dec_result  in  DATA_W  Decipher output
core_data  out  DATA_W  registered input block to Cipher/Decipher

Behaviour:
- Reset (reset_n low, async): state IDLE; in_ready 1; out_valid 0; out_data 0; out_err 00; ke_reset, cip_reset, dec_reset all 1; cache invalid; ke_key, ke_nk, core_data 0; watchdog 0.
- States: IDLE, EXPAND, CRYPT, RESP.
- IDLE: in_ready=1; on accept, register decrypt, nk, key, data. Nk not in {4,6,8} -> RESP with err 01, out_data 0, no core touched. Cache hit (valid, key and Nk equal) -> CRYPT. Else cache invalidated -> EXPAND.
- EXPAND: ke_reset low from first cycle; watchdog counts. ke_done high -> store key/Nk, cache valid, ke_reset stays low (schedule held), -> CRYPT. Watchdog reaches TIMEOUT_CYCLES -> ke_reset 1, cache invalid, RESP err 10.
- CRYPT: selected core reset low (cip_reset or dec_reset), other stays 1; watchdog restarts at 0. done -> capture result into out_data, that core reset back to 1, RESP err 00. Timeout -> core reset 1, RESP err 10, cache kept.
- Core resets are 1 in every cycle outside their active state; guarantees done deasserts before next use (≥1 cycle reset pulse).
- RESP: out_valid=1, out_data/out_err stable until out_ready; then IDLE. in_ready=0 outside IDLE.
- On cache miss, ke_reset pulses 1 for exactly one cycle (entry cycle) then 0.
- flush in any state: cache invalid next cycle; if in EXPAND, current expansion continues but result not cached. flush and accept same cycle: flush wins, request treated as miss.
- Latency: miss = 1 + expansion + cipher + 1 cycles; hit = 1 + cipher + 1.
- Cache comparison covers only the top 32*Nk key bits.
- reset_n mid-operation: all state aborted, no response produced.

Decomposition:
- Package aes_pkg: state enum, error code constants (ERR_OK, ERR_NK, ERR_TMO), legal Nk constants, helper function for Nk legality and key-mask.
- Sub-module aes_watchdog: loadable counter with clear and expiry flag, parameter TIMEOUT_CYCLES.

Test Plan:
- AES-128 encrypt key 000102..0f, data 00112233..eeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, err 00, ke_reset pulsed once.
- Repeat same key, decrypt 69c4e0d8..c55a -> 00112233..eeff, ke_reset stays 0 (cache hit), latency shorter by expansion time.
- AES-192 key 00..17 then AES-256 key 00..1f, same plaintext -> dda97ca4864cdfe06eaf70a0ec0d7191 and 8ea2b7ca516745bfeafc49904b496089, each causing a miss.
- in_nk=5 -> out_err 01, out_data 0, no core reset toggled; in_nk=8 next request completes normally.
- Stub core never asserts cip_done -> err 10 after TIMEOUT_CYCLES, cip_reset back to 1, next request with same key is a cache hit; flush then same key -> miss.
- Hold out_ready 0 for 20 cycles -> out_valid/out_data stable, in_ready 0; reset_n low during EXPAND -> all outputs at reset values, out_valid never asserted.
